branch_resolver: RTL

//  Consumes the condition flags from the branch comparator (zero/bne/blt/bge) plus the

---
 rtl/branch_resolver_pkg.sv | 17 +
 rtl/branch_resolver_if.sv | 31 +++
 rtl/branch_resolver_sat_counter.sv | 24 ++
 rtl/branch_resolver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared constants for the branch resolver: funct3 codes, FSM encoding, XLEN default.
package branch_resolver_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] BR_BEQ = 3'b000;
    localparam logic [2:0] BR_BNE = 3'b001;
    localparam logic [2:0] BR_BLT = 3'b100;
    localparam logic [2:0] BR_BGE = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_FLUSH    = 2'b10
    } br_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// EX-side branch request and IF-side redirect handshake bundled together.
// master = pipeline side (EX drives the branch, IF answers the redirect),
// slave  = the branch resolver.
interface branch_resolver_if
    import branch_resolver_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_func;
    logic            br_zero;
    logic            br_bne;
    logic            br_blt;
    logic            br_bge;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_ready;

    modport master (
        output br_valid, br_func, br_zero, br_bne, br_blt, br_bge, br_pc, br_imm, fetch_ready,
        input  br_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  br_valid, br_func, br_zero, br_bne, br_blt, br_bge, br_pc, br_imm, fetch_ready,
        output br_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_r;

    // Count up on inc until the all-ones ceiling is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/branch_resolver.sv
// Branch resolver between EX and IF: decides taken/not-taken, issues a
// registered PC redirect with handshake, then flushes younger stages.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus,
    output logic             flush,
    output logic             misalign_err,
    output logic             illegal_func,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);
    localparam int FLUSH_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    br_state_e        state_r;
    br_state_e        state_next_s;
    logic [FLUSH_W-1:0] flush_cnt_r;

    logic             accept_s;
    logic             taken_s;
    logic             legal_s;
    logic             misaligned_s;
    logic             handshake_s;
    logic [XLEN-1:0]  target_s;

    logic             redirect_valid_s;
    logic             flush_s;
    logic             br_ready_s;
    logic             misalign_s;
    logic             illegal_s;

    logic             redirect_valid_r;
    logic [XLEN-1:0]  redirect_pc_r;
    logic             flush_r;
    logic             br_ready_r;
    logic             misalign_err_r;
    logic             illegal_func_r;

    assign accept_s     = bus.br_valid & br_ready_r;
    assign handshake_s  = (state_r == ST_REDIRECT) & bus.fetch_ready;
    assign target_s     = bus.br_pc + bus.br_imm;
    assign misaligned_s = (target_s[1:0] != 2'b00);

    // Select the comparator flag that decides the branch for this funct3.
    always_comb begin
        taken_s = 1'b0;
        legal_s = 1'b1;
        case (bus.br_func)
            BR_BEQ:  taken_s = bus.br_zero;
            BR_BNE:  taken_s = bus.br_bne;
            BR_BLT:  taken_s = bus.br_blt;
            BR_BGE:  taken_s = bus.br_bge;
            default: begin
                taken_s = 1'b0;
                legal_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: misaligned targets never leave IDLE, zero flush length skips FLUSH.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s && taken_s && !misaligned_s) begin
                    state_next_s = ST_REDIRECT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (bus.fetch_ready) begin
                    state_next_s = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_IDLE;
                end else begin
                    state_next_s = ST_REDIRECT;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r <= FLUSH_W'(1)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs, computed from the upcoming state so they can be registered.
    always_comb begin
        redirect_valid_s = (state_next_s == ST_REDIRECT);
        flush_s          = (state_next_s != ST_IDLE);
        br_ready_s       = (state_next_s == ST_IDLE);
        misalign_s       = accept_s & legal_s & taken_s & misaligned_s;
        illegal_s        = accept_s & ~legal_s;
    end

    // Flush length down-counter, loaded when IF accepts the redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_r <= {FLUSH_W{1'b0}};
        end else if (handshake_s) begin
            flush_cnt_r <= FLUSH_W'(FLUSH_CYCLES);
        end else if ((state_r == ST_FLUSH) && (flush_cnt_r != {FLUSH_W{1'b0}})) begin
            flush_cnt_r <= flush_cnt_r - FLUSH_W'(1);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Output registers; redirect_pc is captured only on entry to REDIRECT so it stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
            flush_r          <= 1'b0;
            br_ready_r       <= 1'b1;
            misalign_err_r   <= 1'b0;
            illegal_func_r   <= 1'b0;
        end else begin
            redirect_valid_r <= redirect_valid_s;
            flush_r          <= flush_s;
            br_ready_r       <= br_ready_s;
            misalign_err_r   <= misalign_s;
            illegal_func_r   <= illegal_s;
            if ((state_r == ST_IDLE) && (state_next_s == ST_REDIRECT)) begin
                redirect_pc_r <= target_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept_s),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake_s),
        .count (taken_count)
    );

    assign bus.br_ready       = br_ready_r;
    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign flush              = flush_r;
    assign misalign_err       = misalign_err_r;
    assign illegal_func       = illegal_func_r;
endmodule
